// File: rtl/hadamard_sequencer_pkg.sv
// Shared types and constants for the Hadamard sequencer: FSM states, SFP widths, twiddle table.
package hadamard_sequencer_pkg;

    localparam int unsigned DEF_EXP_W = 4;
    localparam int unsigned DEF_SIG_W = 4;
    localparam int unsigned DEF_FMT_W = 1 + DEF_EXP_W + DEF_SIG_W;
    localparam int unsigned LANES     = 4;

    typedef enum logic [1:0] {
        StFill,
        StIssue,
        StWait,
        StDrain
    } seq_state_e;

    // +1.0 is biased exponent with zero significand; -1.0 only differs in the sign bit.
    localparam logic [DEF_FMT_W-1:0] SFP_ZERO = '0;
    localparam logic [DEF_FMT_W-1:0] SFP_ONE  =
        {1'b0, DEF_EXP_W'((1 << (DEF_EXP_W - 1)) - 1), DEF_SIG_W'(0)};
    localparam logic [DEF_FMT_W-1:0] SFP_NEG  =
        {1'b1, DEF_EXP_W'((1 << (DEF_EXP_W - 1)) - 1), DEF_SIG_W'(0)};

    // Indexed [set][lane].
    localparam logic [DEF_FMT_W-1:0] TW_REAL [4][4] = '{
        '{SFP_ONE, SFP_ONE,  SFP_ONE, SFP_ONE },
        '{SFP_ONE, SFP_ZERO, SFP_NEG, SFP_ZERO},
        '{SFP_ONE, SFP_NEG,  SFP_ONE, SFP_NEG },
        '{SFP_ONE, SFP_ZERO, SFP_NEG, SFP_ZERO}
    };

    localparam logic [DEF_FMT_W-1:0] TW_IMAG [4][4] = '{
        '{SFP_ZERO, SFP_ZERO, SFP_ZERO, SFP_ZERO},
        '{SFP_ZERO, SFP_NEG,  SFP_ZERO, SFP_ONE },
        '{SFP_ZERO, SFP_ZERO, SFP_ZERO, SFP_ZERO},
        '{SFP_ZERO, SFP_ONE,  SFP_ZERO, SFP_NEG }
    };

endpackage

// File: rtl/hadamard_sequencer_lane_buffer.sv
// Four-lane complex register file: single-lane indexed write, all-lane load, indexed read.
module lane_buffer
    import hadamard_sequencer_pkg::*;
#(
    parameter int unsigned FMT_W = DEF_FMT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [1:0]             wr_idx_i,
    input  logic [FMT_W-1:0]       wr_real_i,
    input  logic [FMT_W-1:0]       wr_imag_i,
    input  logic                   ld_en_i,
    input  logic [LANES*FMT_W-1:0] ld_real_i,
    input  logic [LANES*FMT_W-1:0] ld_imag_i,
    input  logic [1:0]             rd_idx_i,
    output logic [FMT_W-1:0]       rd_real_o,
    output logic [FMT_W-1:0]       rd_imag_o,
    output logic [LANES*FMT_W-1:0] all_real_o,
    output logic [LANES*FMT_W-1:0] all_imag_o
);

    logic [LANES-1:0][FMT_W-1:0] real_q, real_d;
    logic [LANES-1:0][FMT_W-1:0] imag_q, imag_d;

    always_comb begin
        real_d = real_q;
        imag_d = imag_q;
        if (ld_en_i) begin
            real_d = ld_real_i;
            imag_d = ld_imag_i;
        end else if (wr_en_i) begin
            real_d[wr_idx_i] = wr_real_i;
            imag_d[wr_idx_i] = wr_imag_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            real_q <= '0;
            imag_q <= '0;
        end else begin
            real_q <= real_d;
            imag_q <= imag_d;
        end
    end

    assign rd_real_o  = real_q[rd_idx_i];
    assign rd_imag_o  = imag_q[rd_idx_i];
    assign all_real_o = real_q;
    assign all_imag_o = imag_q;

endmodule

// File: rtl/hadamard_sequencer.sv
// Gathers four complex samples, runs them through the external Hadamard core with the current
// twiddle set, then streams the four results out; one block at a time.
module hadamard_sequencer
    import hadamard_sequencer_pkg::*;
#(
    parameter int unsigned EXP_W   = DEF_EXP_W,
    parameter int unsigned SIG_W   = DEF_SIG_W,
    parameter int unsigned FMT_W   = DEF_FMT_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FMT_W-1:0]       in_real,
    input  logic [FMT_W-1:0]       in_imag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FMT_W-1:0]       out_real,
    output logic [FMT_W-1:0]       out_imag,
    output logic                   out_last,
    output logic                   core_start,
    output logic [LANES*FMT_W-1:0] core_in_real,
    output logic [LANES*FMT_W-1:0] core_in_imag,
    output logic [LANES*FMT_W-1:0] core_tw_real,
    output logic [LANES*FMT_W-1:0] core_tw_imag,
    input  logic [LANES*FMT_W-1:0] core_out_real,
    input  logic [LANES*FMT_W-1:0] core_out_imag,
    input  logic                   core_done,
    output logic [1:0]             grp,
    output logic                   err
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (FMT_W != 1 + EXP_W + SIG_W) begin : g_fmt_check
        $error("FMT_W must equal 1 + EXP_W + SIG_W");
    end

    seq_state_e      state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [1:0]      m_q, m_d;
    logic [1:0]      grp_q, grp_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic            in_wr, out_ld;

    logic [FMT_W-1:0]       unused_in_rd_real, unused_in_rd_imag;
    logic [LANES*FMT_W-1:0] unused_out_all_real, unused_out_all_imag;

    // Gated by rst so the stream reads not-ready while reset is held.
    assign in_ready = rst && (state_q == StFill);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        m_d        = m_q;
        grp_d      = grp_q;
        wcnt_d     = wcnt_q;
        in_wr      = 1'b0;
        out_ld     = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            StFill: begin
                if (in_valid && in_ready) begin
                    in_wr = 1'b1;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'd3) state_d = StIssue;
                end
            end
            StIssue: begin
                core_start = 1'b1;
                wcnt_d     = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (core_done) begin
                    out_ld  = 1'b1;
                    wcnt_d  = '0;
                    m_d     = 2'd0;
                    state_d = StDrain;
                end else if (wcnt_q == CntW'(TIMEOUT)) begin
                    // Core never answered: drop the block, keep the twiddle set.
                    err     = 1'b1;
                    wcnt_d  = '0;
                    k_d     = 2'd0;
                    state_d = StFill;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    m_d = m_q + 2'd1;
                    if (m_q == 2'd3) begin
                        grp_d   = grp_q + 2'd1;
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFill;
            k_q     <= 2'd0;
            m_q     <= 2'd0;
            grp_q   <= 2'd0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
            grp_q   <= grp_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign out_last = out_valid && (m_q == 2'd3);
    assign grp      = grp_q;

    always_comb begin
        core_tw_real = '0;
        core_tw_imag = '0;
        for (int l = 0; l < LANES; l++) begin
            core_tw_real[l*FMT_W +: FMT_W] = FMT_W'(TW_REAL[grp_q][l]);
            core_tw_imag[l*FMT_W +: FMT_W] = FMT_W'(TW_IMAG[grp_q][l]);
        end
    end

    lane_buffer #(
        .FMT_W (FMT_W)
    ) u_in_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (in_wr),
        .wr_idx_i   (k_q),
        .wr_real_i  (in_real),
        .wr_imag_i  (in_imag),
        .ld_en_i    (1'b0),
        .ld_real_i  ('0),
        .ld_imag_i  ('0),
        .rd_idx_i   (2'd0),
        .rd_real_o  (unused_in_rd_real),
        .rd_imag_o  (unused_in_rd_imag),
        .all_real_o (core_in_real),
        .all_imag_o (core_in_imag)
    );

    lane_buffer #(
        .FMT_W (FMT_W)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (1'b0),
        .wr_idx_i   (2'd0),
        .wr_real_i  ('0),
        .wr_imag_i  ('0),
        .ld_en_i    (out_ld),
        .ld_real_i  (core_out_real),
        .ld_imag_i  (core_out_imag),
        .rd_idx_i   (m_q),
        .rd_real_o  (out_real),
        .rd_imag_o  (out_imag),
        .all_real_o (unused_out_all_real),
        .all_imag_o (unused_out_all_imag)
    );

endmodule

// File: tb/tb_hadamard_sequencer.sv
// Directed self-checking bench for hadamard_sequencer with a behavioural Hadamard-core stand-in.
module tb_hadamard_sequencer;

    localparam int W  = 9;
    localparam int WW = 4 * W;
    localparam logic [W-1:0] ONE = 9'h070;
    localparam logic [W-1:0] NEG = 9'h170;
    localparam logic [W-1:0] ZRO = 9'h000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_real = '0, in_imag = '0;
    logic          out_valid, out_ready = 1'b1, out_last;
    logic [W-1:0]  out_real, out_imag;
    logic          core_start, core_done, err;
    logic [WW-1:0] core_in_real, core_in_imag, core_tw_real, core_tw_imag;
    logic [WW-1:0] core_out_real, core_out_imag;
    logic [1:0]    grp;

    always #5 clk = ~clk;

    hadamard_sequencer #(
        .EXP_W   (4),
        .SIG_W   (4),
        .FMT_W   (W),
        .TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_real       (in_real),
        .in_imag       (in_imag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_real      (out_real),
        .out_imag      (out_imag),
        .out_last      (out_last),
        .core_start    (core_start),
        .core_in_real  (core_in_real),
        .core_in_imag  (core_in_imag),
        .core_tw_real  (core_tw_real),
        .core_tw_imag  (core_tw_imag),
        .core_out_real (core_out_real),
        .core_out_imag (core_out_imag),
        .core_done     (core_done),
        .grp           (grp),
        .err           (err)
    );

    // Core stand-in: done 4 cycles after start, each lane returned as input + 1.
    logic          done_en = 1'b1;
    logic          spur = 1'b0;
    int            dly = 0;
    logic [WW-1:0] cap_r = '0, cap_i = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly <= 0;
        end else if (core_start) begin
            dly   <= 4;
            cap_r <= core_in_real;
            cap_i <= core_in_imag;
        end else if (dly != 0) begin
            dly <= dly - 1;
        end
    end

    assign core_done = (done_en && dly == 1) || spur;

    always_comb begin
        core_out_real = '0;
        core_out_imag = '0;
        for (int l = 0; l < 4; l++) begin
            core_out_real[l*W +: W] = cap_r[l*W +: W] + 9'd1;
            core_out_imag[l*W +: W] = cap_i[l*W +: W] + 9'd1;
        end
    end

    // Event monitors.
    int            starts = 0, errs = 0, err_at = -1, cyc = 0, ov_cnt = 0;
    logic [WW-1:0] st_tw_r = '0, st_tw_i = '0, st_in_r = '0, st_in_i = '0;

    always @(posedge clk) begin
        if (core_start) begin
            starts  <= starts + 1;
            st_tw_r <= core_tw_real;
            st_tw_i <= core_tw_imag;
            st_in_r <= core_in_real;
            st_in_i <= core_in_imag;
            cyc     <= 0;
        end else begin
            cyc <= cyc + 1;
        end
        if (err) begin
            errs   <= errs + 1;
            err_at <= cyc;
        end
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_grp = 0;
    logic [WW-1:0] tw_r [4];
    logic [WW-1:0] tw_i [4];

    function automatic logic [WW-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                            input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] i);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_real  = r;
        in_imag  = i;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Drain one block; with stall set, out_ready follows 1,0,0,1,0,0...
    task automatic recv(input string tag, input logic [WW-1:0] er, input logic [WW-1:0] ei,
                        input bit stall);
        int got = 0, n = 0, ph = 0;
        bit prev_stall = 0;
        logic [W-1:0] pr = '0, pi = '0;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            n++;
            out_ready = stall ? (ph % 3 == 0) : 1'b1;
            if (out_valid) begin
                if (prev_stall) begin
                    chk({tag, "_stall_real"}, out_real, pr);
                    chk({tag, "_stall_imag"}, out_imag, pi);
                end
                if (out_ready) begin
                    chk({tag, "_real"}, out_real, er[got*W +: W]);
                    chk({tag, "_imag"}, out_imag, ei[got*W +: W]);
                    chk({tag, "_last"}, out_last, (got == 3));
                    got++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    pr = out_real;
                    pi = out_imag;
                end
                ph++;
            end
        end
        chk({tag, "_count"}, got, 4);
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, "_valid_after"}, out_valid, 0);
    endtask

    task automatic run_block(input string tag, input logic [W-1:0] br, input logic [W-1:0] bi,
                             input bit stall);
        logic [WW-1:0] xr, xi, ir, ii;
        int s0 = starts;
        chk({tag, "_grp_before"}, grp, exp_grp);
        for (int i = 0; i < 4; i++) begin
            ir[i*W +: W] = br + W'(i);
            ii[i*W +: W] = bi;
            xr[i*W +: W] = br + W'(i) + 9'd1;
            xi[i*W +: W] = bi + 9'd1;
        end
        for (int i = 0; i < 4; i++) send(ir[i*W +: W], bi);
        recv(tag, xr, xi, stall);
        chk({tag, "_starts"}, starts - s0, 1);
        chk({tag, "_core_in_r"}, st_in_r, ir);
        chk({tag, "_core_in_i"}, st_in_i, ii);
        chk({tag, "_tw_r"}, st_tw_r, tw_r[exp_grp]);
        chk({tag, "_tw_i"}, st_tw_i, tw_i[exp_grp]);
        exp_grp = (exp_grp + 1) % 4;
        chk({tag, "_grp_after"}, grp, exp_grp);
    endtask

    initial begin
        int s0, e0, o0, n;
        tw_r[0] = pack4(ONE, ONE, ONE, ONE);
        tw_i[0] = pack4(ZRO, ZRO, ZRO, ZRO);
        tw_r[1] = pack4(ONE, ZRO, NEG, ZRO);
        tw_i[1] = pack4(ZRO, NEG, ZRO, ONE);
        tw_r[2] = pack4(ONE, NEG, ONE, NEG);
        tw_i[2] = pack4(ZRO, ZRO, ZRO, ZRO);
        tw_r[3] = pack4(ONE, ZRO, NEG, ZRO);
        tw_i[3] = pack4(ZRO, ONE, ZRO, NEG);

        // Reset state.
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_err", err, 0);
        chk("rst_core_in_r", core_in_real, 0);
        chk("rst_grp", grp, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Timeout: core never answers.
        done_en = 1'b0;
        e0 = errs;
        o0 = ov_cnt;
        for (int i = 0; i < 4; i++) send(9'h0B0 + 9'(i), 9'h000);
        n = 0;
        while (errs == e0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("to_err_pulses", errs - e0, 1);
        chk("to_err_at", err_at, 15);
        chk("to_grp", grp, 0);
        chk("to_no_output", ov_cnt - o0, 0);
        chk("to_in_ready", in_ready, 1);
        done_en = 1'b1;

        // Five consecutive blocks: grp 0,1,2,3,0.
        run_block("blk0", 9'h0A0, 9'h000, 0);
        run_block("blk1_stall", 9'h0A0, 9'h000, 1);
        run_block("blk2", 9'h150, 9'h011, 0);
        run_block("blk3", 9'h1F0, 9'h100, 0);
        run_block("blk4_stall", 9'h033, 9'h044, 1);

        // Spurious core_done during FILL with two samples loaded.
        s0 = starts;
        send(9'h060, 9'h007);
        send(9'h061, 9'h007);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spur_no_output", out_valid, 0);
        send(9'h062, 9'h007);
        send(9'h063, 9'h007);
        recv("spur", pack4(9'h061, 9'h062, 9'h063, 9'h064),
             pack4(9'h008, 9'h008, 9'h008, 9'h008), 0);
        chk("spur_starts", starts - s0, 1);
        exp_grp = (exp_grp + 1) % 4;
        chk("spur_grp", grp, exp_grp);

        // Reset while waiting on the core.
        done_en = 1'b0;
        s0 = starts;
        for (int i = 0; i < 4; i++) send(9'h0D0 + 9'(i), 9'h000);
        n = 0;
        while (starts == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mr_start_seen", starts - s0, 1);
        repeat (2) @(negedge clk);
        o0 = ov_cnt;
        rst = 1'b0;
        #1;
        chk("mr_in_ready", in_ready, 0);
        chk("mr_core_start", core_start, 0);
        chk("mr_core_in_r", core_in_real, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_en = 1'b1;
        #1;
        chk("mr_rel_in_ready", in_ready, 1);
        chk("mr_grp", grp, 0);
        s0 = starts;
        repeat (10) @(negedge clk);
        chk("mr_no_valid", ov_cnt - o0, 0);
        chk("mr_no_start", starts - s0, 0);
        exp_grp = 0;
        run_block("post_rst", 9'h0C0, 9'h005, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
